// File: rtl/alu_nibble_sequencer_pkg.sv
// Shared types and select codes for the nibble-serial ALU sequencer.
// Command bundle, FSM states and common 74181 function selects.
package alu_nibble_sequencer_pkg;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
    logic       cin;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_AND = 4'b1011;

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Command, response and slice-drive signals of the sequencer.
// master: producer/consumer/slice side; slave: the sequencer.
interface alu_nibble_sequencer_if #(
  parameter int WIDTH = 16
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_s;
  logic             cmd_m;
  logic             cmd_cin;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic [3:0]       alu_s;
  logic             alu_m;
  logic             alu_cn_n;
  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [3:0]       alu_f;
  logic             alu_cn4_n;
  logic             alu_aeqb;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_f;
  logic             rsp_cout;
  logic             rsp_aeqb;

  modport master (
    output cmd_valid, cmd_s, cmd_m,
    output cmd_cin, cmd_a, cmd_b,
    output rsp_ready,
    output alu_f, alu_cn4_n, alu_aeqb,
    input  cmd_ready,
    input  rsp_valid, rsp_f,
    input  rsp_cout, rsp_aeqb,
    input  alu_s, alu_m, alu_cn_n,
    input  alu_a, alu_b
  );

  modport slave (
    input  cmd_valid, cmd_s, cmd_m,
    input  cmd_cin, cmd_a, cmd_b,
    input  rsp_ready,
    input  alu_f, alu_cn4_n, alu_aeqb,
    output cmd_ready,
    output rsp_valid, rsp_f,
    output rsp_cout, rsp_aeqb,
    output alu_s, alu_m, alu_cn_n,
    output alu_a, alu_b
  );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one WIDTH-bit op as WIDTH/4 LSB-first passes through a 4-bit slice.
// Ports: clk, rst_n (sync, active-low), bus (cmd / slice / rsp channels).
module alu_nibble_sequencer
  import alu_nibble_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_nibble_sequencer_if.slave bus
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = $clog2(NIB);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  seq_state_t       state_q, state_d;
  alu_cmd_t         cmd_in;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             aeqb_q, aeqb_d;
  logic             live_q, live_d;

  assign cmd_in = '{
    s:   bus.cmd_s,
    m:   bus.cmd_m,
    cin: bus.cmd_cin
  };

  assign bus.rsp_f    = f_q;
  assign bus.rsp_cout = carry_q;
  assign bus.rsp_aeqb = aeqb_q;

  always_comb begin
    state_d       = state_q;
    s_d           = s_q;
    m_d           = m_q;
    a_d           = a_q;
    b_d           = b_q;
    f_d           = f_q;
    idx_d         = idx_q;
    carry_d       = carry_q;
    aeqb_d        = aeqb_q;
    // Holds cmd_ready low for the first cycle after reset.
    live_d        = 1'b1;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.alu_s     = 4'b0000;
    bus.alu_m     = 1'b1;
    bus.alu_cn_n  = 1'b1;
    bus.alu_a     = 4'h0;
    bus.alu_b     = 4'h0;
    unique case (state_q)
      IDLE: begin
        bus.cmd_ready = live_q;
        if (live_q && bus.cmd_valid) begin
          s_d     = cmd_in.s;
          m_d     = cmd_in.m;
          a_d     = bus.cmd_a;
          b_d     = bus.cmd_b;
          // Logic mode never feeds a carry into the slice.
          carry_d = cmd_in.m ? 1'b0 : cmd_in.cin;
          idx_d   = '0;
          aeqb_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        bus.alu_s    = s_q;
        bus.alu_m    = m_q;
        bus.alu_cn_n = ~carry_q;
        bus.alu_a    = a_q[{idx_q, 2'b00} +: 4];
        bus.alu_b    = b_q[{idx_q, 2'b00} +: 4];
        f_d[{idx_q, 2'b00} +: 4] = bus.alu_f;
        carry_d = m_q ? 1'b0 : ~bus.alu_cn4_n;
        aeqb_d  = aeqb_q & bus.alu_aeqb;
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q     <= '0;
      m_q     <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      aeqb_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      m_q     <= m_d;
      a_q     <= a_d;
      b_q     <= b_d;
      f_q     <= f_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      aeqb_q  <= aeqb_d;
      live_q  <= live_d;
    end
  end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer with a behavioural 4-bit slice.
// Directed and random ops; expected results flow through a queue.
module tb_alu_nibble_sequencer;
  import alu_nibble_sequencer_pkg::*;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] f;
    logic         cout;
    logic         aeqb;
  } exp_t;

  logic clk;
  logic rst_n;
  int   ntot;
  int   npass;
  exp_t sb[$];

  alu_nibble_sequencer_if #(.WIDTH(W)) bus ();

  alu_nibble_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] lfn(
    input logic [3:0]   s,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] r;
    r = '0;
    case (s)
      4'h0: r = ~a;
      4'h1: r = ~(a | b);
      4'h2: r = ~a & b;
      4'h3: r = '0;
      4'h4: r = ~(a & b);
      4'h5: r = ~b;
      4'h6: r = a ^ b;
      4'h7: r = a & ~b;
      4'h8: r = ~a | b;
      4'h9: r = ~(a ^ b);
      4'hA: r = b;
      4'hB: r = a & b;
      4'hC: r = '1;
      4'hD: r = a | ~b;
      4'hE: r = a | b;
      default: r = a;
    endcase
    return r;
  endfunction

  // Arithmetic as X + Y + cin, the 74181 internal decomposition.
  function automatic exp_t ref_op(
    input logic [3:0]   s,
    input logic         m,
    input logic         cin,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    exp_t       e;
    logic [W-1:0] x, y;
    logic [W:0] sum;
    x = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y = (a & ~b & {W{s[2]}}) | (a & b & {W{s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
    e.aeqb = (a == b);
    if (m) begin
      e.f    = lfn(s, a, b);
      e.cout = 1'b0;
    end else begin
      e.f    = sum[W-1:0];
      e.cout = sum[W];
    end
    return e;
  endfunction

  // Behavioural slice on the sequencer's drive.
  always_comb begin
    logic [3:0]   x, y;
    logic [4:0]   sum;
    logic [W-1:0] lf;
    x = bus.alu_a
      | (bus.alu_b & {4{bus.alu_s[0]}})
      | (~bus.alu_b & {4{bus.alu_s[1]}});
    y = (bus.alu_a & ~bus.alu_b & {4{bus.alu_s[2]}})
      | (bus.alu_a & bus.alu_b & {4{bus.alu_s[3]}});
    sum = {1'b0, x} + {1'b0, y} + {4'b0, ~bus.alu_cn_n};
    lf  = lfn(bus.alu_s,
              {{(W-4){1'b0}}, bus.alu_a},
              {{(W-4){1'b0}}, bus.alu_b});
    bus.alu_aeqb = (bus.alu_a == bus.alu_b);
    if (bus.alu_m) begin
      bus.alu_f     = lf[3:0];
      bus.alu_cn4_n = 1'b1;
    end else begin
      bus.alu_f     = sum[3:0];
      bus.alu_cn4_n = ~sum[4];
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rsp_f"}, 32'(bus.rsp_f), 0);
    chk({tag, "_rsp_cout"}, 32'(bus.rsp_cout), 0);
    chk({tag, "_rsp_aeqb"}, 32'(bus.rsp_aeqb), 0);
    chk({tag, "_alu_m"}, 32'(bus.alu_m), 1);
    chk({tag, "_alu_cn_n"}, 32'(bus.alu_cn_n), 1);
    chk({tag, "_alu_ab"}, {24'b0, bus.alu_a, bus.alu_b}, 0);
    chk({tag, "_alu_s"}, 32'(bus.alu_s), 0);
  endtask

  // Called at a negedge; returns at the negedge after the rsp handshake.
  task automatic run_op(
    input string        tag,
    input logic [3:0]   s,
    input logic         m,
    input logic         cin,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input exp_t         e,
    input int           hold
  );
    int   n;
    int   k;
    exp_t got;
    bus.cmd_valid = 1'b1;
    bus.cmd_s     = s;
    bus.cmd_m     = m;
    bus.cmd_cin   = cin;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(bus.cmd_ready), 1);
    sb.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    while (!bus.rsp_valid && k < 20) begin
      chk({tag, "_run_ready"}, 32'(bus.cmd_ready), 0);
      if (k < NIB) begin
        chk({tag, "_alu_a"}, 32'(bus.alu_a), 32'(a[4*k +: 4]));
        chk({tag, "_alu_b"}, 32'(bus.alu_b), 32'(b[4*k +: 4]));
      end
      if (m) begin
        chk({tag, "_cn_n"}, 32'(bus.alu_cn_n), 1);
      end
      @(negedge clk);
      k++;
    end
    // Edges from accept to the first edge that samples rsp_valid.
    chk({tag, "_latency"}, k + 1, NIB + 1);
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, 32'(bus.rsp_valid), 1);
      chk({tag, "_hold_f"}, 32'(bus.rsp_f), 32'(e.f));
      chk({tag, "_hold_ready"}, 32'(bus.cmd_ready), 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 1);
    got = sb.pop_front();
    chk({tag, "_f"}, 32'(bus.rsp_f), 32'(got.f));
    chk({tag, "_cout"}, 32'(bus.rsp_cout), 32'(got.cout));
    chk({tag, "_aeqb"}, 32'(bus.rsp_aeqb), 32'(got.aeqb));
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_post_ready"}, 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    exp_t         e;
    logic [3:0]   rs;
    logic [W-1:0] ra, rb;
    logic         rm, rc;
    ntot          = 0;
    npass         = 0;
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_s     = 4'h0;
    bus.cmd_m     = 1'b0;
    bus.cmd_cin   = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    chk("rst_rel_ready", 32'(bus.cmd_ready), 0);
    @(negedge clk);
    chk("rst_first_ready", 32'(bus.cmd_ready), 1);

    e = '{f: 16'h0100, cout: 1'b0, aeqb: 1'b0};
    run_op("add", S_ADD, 1'b0, 1'b0,
           16'h00FF, 16'h0001, e, 0);

    e = '{f: 16'h0000, cout: 1'b1, aeqb: 1'b0};
    run_op("add_co", S_ADD, 1'b0, 1'b0,
           16'hFFFF, 16'h0001, e, 0);

    e = '{f: 16'h0000, cout: 1'b1, aeqb: 1'b1};
    run_op("sub_eq", S_SUB, 1'b0, 1'b1,
           16'h1234, 16'h1234, e, 0);

    e = '{f: 16'hFFFF, cout: 1'b0, aeqb: 1'b0};
    run_op("sub_ne", S_SUB, 1'b0, 1'b1,
           16'h1234, 16'h1235, e, 0);

    e = '{f: 16'hAAAA, cout: 1'b0, aeqb: 1'b0};
    run_op("xor", S_XOR, 1'b1, 1'b1,
           16'hA5A5, 16'h0F0F, e, 0);

    e = '{f: 16'h3030, cout: 1'b0, aeqb: 1'b0};
    run_op("bp_and", S_AND, 1'b1, 1'b0,
           16'hF0F0, 16'h3C3C, e, 3);

    e = '{f: 16'h0002, cout: 1'b0, aeqb: 1'b1};
    run_op("b2b_add", S_ADD, 1'b0, 1'b0,
           16'h0001, 16'h0001, e, 0);

    // Abort during the second pass; nothing is queued.
    bus.cmd_valid = 1'b1;
    bus.cmd_s     = S_ADD;
    bus.cmd_m     = 1'b0;
    bus.cmd_cin   = 1'b1;
    bus.cmd_a     = 16'hFFFF;
    bus.cmd_b     = 16'hFFFF;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals("abort");
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(bus.cmd_ready), 1);
    chk("abort_no_rsp", 32'(bus.rsp_valid), 0);

    e = '{f: 16'h5555, cout: 1'b0, aeqb: 1'b0};
    run_op("after_rst", S_ADD, 1'b0, 1'b0,
           16'h1234, 16'h4321, e, 0);

    for (int i = 0; i < 6; i++) begin
      rs = 4'($urandom_range(15, 0));
      rm = 1'($urandom_range(1, 0));
      rc = 1'($urandom_range(1, 0));
      ra = 16'($urandom);
      rb = (i == 2) ? ra : 16'($urandom);
      e  = ref_op(rs, rm, rc, ra, rb);
      run_op($sformatf("rnd%0d", i), rs, rm, rc,
             ra, rb, e, i % 3);
    end

    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
